// File: rtl/tdes_round_sequencer.sv
// tdes_round_sequencer
// Steps one shared DES round core through a full Triple-DES chunk. Each chunk
// takes three passes of ROUNDS rounds, E-D-E for encrypt or D-E-D for decrypt.
// The finished chunk is held in out_data until the slave acknowledges it.
// Build option: define TDES_INBUF_EN to add a one-deep input buffer, so that a
// new chunk can be accepted while the current one is still being processed.

module tdes_round_sequencer #(
    parameter int DATA_W = 64,
    parameter int ROUNDS = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              soft_clr,
    input  logic              enc_dec,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              core_load,
    output logic [DATA_W-1:0] core_data,
    output logic              core_round,
    output logic              core_swap,
    output logic [1:0]        key_sel,
    output logic              key_dec,
    output logic [1:0]        shift_amt,
    output logic [1:0]        pass_num,
    output logic [3:0]        round_num,
    input  logic [DATA_W-1:0] core_result,
    output logic              out_valid,
    input  logic              out_ack,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        SWAP,
        CAPT
    } state_e;

    localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

    state_e            state_q, state_d;
    logic [1:0]        pass_q, pass_d;
    logic [3:0]        round_q, round_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] chunk_q, chunk_d;
    logic              buf_valid_q, buf_valid_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              accept;
    logic              pending;
    logic              in_pass;

`ifdef TDES_INBUF_EN
    assign in_ready = ~buf_valid_q & ~soft_clr;
`else
    assign in_ready = (state_q == IDLE) & ~soft_clr;
`endif

    assign accept  = in_valid & in_ready;
    assign pending = buf_valid_q | accept;

    // Next-state logic: sequences LOAD, ROUND and SWAP, then parks in CAPT until the result register is free
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        round_d     = round_q;
        mode_d      = mode_q;
        chunk_d     = chunk_q;
        buf_valid_d = buf_valid_q;
        out_valid_d = out_valid_q & ~out_ack;
        out_data_d  = out_data_q;

        if (accept) begin
            chunk_d     = in_data;
            buf_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pending) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                mode_d      = enc_dec;
                pass_d      = 2'd0;
                round_d     = 4'd0;
                buf_valid_d = accept;
                state_d     = ROUND;
            end
            ROUND: begin
                if (round_q == LAST_RND) begin
                    state_d = SWAP;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            SWAP: begin
                if (pass_q < 2'd2) begin
                    pass_d  = pass_q + 2'd1;
                    round_d = 4'd0;
                    state_d = ROUND;
                end else begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                if (~out_valid_q | out_ack) begin
                    out_data_d  = core_result;
                    out_valid_d = 1'b1;
                    if (pending) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                        pass_d  = 2'd0;
                        round_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (soft_clr) begin
            state_d     = IDLE;
            pass_d      = 2'd0;
            round_d     = 4'd0;
            buf_valid_d = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers, cleared asynchronously by HRESET
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q     <= IDLE;
            pass_q      <= 2'd0;
            round_q     <= 4'd0;
            mode_q      <= 1'b0;
            chunk_q     <= '0;
            buf_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            round_q     <= round_d;
            mode_q      <= mode_d;
            chunk_q     <= chunk_d;
            buf_valid_q <= buf_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_pass    = (state_q == ROUND) || (state_q == SWAP);
    assign core_load  = (state_q == LOAD);
    assign core_data  = chunk_q;
    assign core_round = (state_q == ROUND);
    assign core_swap  = (state_q == SWAP);
    assign pass_num   = pass_q;
    assign round_num  = round_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = (state_q != IDLE);

    // Key controls: the pass map selects key and direction, the round selects the schedule rotate
    always_comb begin
        key_sel   = 2'd0;
        key_dec   = 1'b0;
        shift_amt = 2'd0;
        if (in_pass) begin
            key_sel = mode_q ? pass_q : (2'd2 - pass_q);
            key_dec = mode_q ? (pass_q == 2'd1) : (pass_q != 2'd1);
        end
        if (state_q == ROUND) begin
            if (key_dec && (round_q == 4'd0)) begin
                shift_amt = 2'd0;
            end else if ((round_q == 4'd0) || (round_q == 4'd1) ||
                         (round_q == 4'd8) || (round_q == LAST_RND)) begin
                shift_amt = 2'd1;
            end else begin
                shift_amt = 2'd2;
            end
        end
    end

endmodule
